// File: rtl/axi4_lite_master_seq.sv
// axi4_lite_master_seq: single-outstanding AXI4-Lite master driven by a cmd/rsp handshake
// Optional response timeout (SLVERR + rsp_timeout) enabled by defining AXI4L_MST_SEQ_TIMEOUT_EN.
module axi4_lite_master_seq #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [P_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
`ifdef AXI4L_MST_SEQ_TIMEOUT_EN
    output logic                      rsp_timeout,
`endif
    output logic                      awvalid,
    input  logic                      awready,
    output logic [P_ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]                awprot,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [P_DATA_WIDTH-1:0]   wdata,
    output logic [P_DATA_WIDTH/8-1:0] wstrb,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [P_ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]                arprot,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [P_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                rresp
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
    state_t state;
    logic aw_done, w_done, tmo;
    assign awprot = 3'b000;
    assign arprot = 3'b000;
`ifdef AXI4L_MST_SEQ_TIMEOUT_EN
    localparam int cnt_w = $clog2(P_TIMEOUT + 1) > 8 ? $clog2(P_TIMEOUT + 1) : 8;
    state_t prev;
    logic [cnt_w-1:0] cnt, elapsed;
    logic waiting;
    assign waiting = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
    // elapsed restarts at zero in the first cycle of every new state
    assign elapsed = (state != prev) ? '0 : cnt + 1'b1;
    assign tmo     = waiting && (elapsed == cnt_w'(P_TIMEOUT - 1));
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prev        <= IDLE;
            cnt         <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            prev        <= state;
            cnt         <= waiting ? elapsed : '0;
            rsp_timeout <= tmo || (rsp_timeout && !(rsp_valid && rsp_ready));
        end
    end
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            rready    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else if (tmo) begin
            state     <= RSP;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b10;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= !(cmd_valid && cmd_ready);
                    if (cmd_valid && cmd_ready) begin
                        awaddr  <= cmd_addr;
                        araddr  <= cmd_addr;
                        wdata   <= cmd_wdata;
                        wstrb   <= cmd_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        awvalid <= cmd_write;
                        wvalid  <= cmd_write;
                        arvalid <= !cmd_write;
                        state   <= cmd_write ? WR_REQ : RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: if (bvalid) begin
                    bready    <= 1'b0;
                    rsp_resp  <= bresp;
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RD_REQ: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= RD_DATA;
                end
                RD_DATA: if (rvalid) begin
                    rready    <= 1'b0;
                    rsp_rdata <= rdata;
                    rsp_resp  <= rresp;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
